// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table and polarity helpers for the seven-segment scan driver
package seg7_pkg;

  localparam int SEG_COUNT = 7;

  // Active-high {G,F,E,D,C,B,A} per hex digit; entry 0 sits in the low bits
  localparam logic [16*SEG_COUNT-1:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_COUNT:0] seg_off(input logic common_anode);
    return common_anode ? {(SEG_COUNT+1){1'b1}} : {(SEG_COUNT+1){1'b0}};
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - hex nibble to active-high seven-segment pattern
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0]           nibble_i,
  output logic [SEG_COUNT-1:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_TABLE[nibble_i*SEG_COUNT +: SEG_COUNT];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scanner with staged loads and dead-cycle anti-ghosting
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    busy_o,
  output logic                    frame_o
);

  localparam int                    CNT_W    = $clog2(CLK_DIV);
  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = seg_off(COMMON_ANODE);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{COMMON_ANODE}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                    busy_q, busy_d, frame_q, frame_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick, wrap, hi_zero, dp_bit;
  logic [3:0]              nibble;
  logic [SEG_COUNT-1:0]    glyph;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [7:0]              raw;

  seg7_hex_lut u_lut (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    tick = en_i && (cnt_q == CNT_LAST);
    wrap = tick && (idx_q == IDX_LAST);
  end

  // Select the current digit and detect whether it and every higher digit are zero
  always_comb begin
    nibble  = 4'd0;
    an_sel  = '0;
    dp_bit  = 1'b0;
    hi_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble    = disp_val_q[i*4 +: 4];
        an_sel[i] = 1'b1;
        dp_bit    = disp_dp_q[i];
      end
      if ((i >= int'(idx_q)) && (disp_val_q[i*4 +: 4] != 4'd0)) begin
        hi_zero = 1'b0;
      end
    end
    raw = {dp_bit, (blank_lz_i && hi_zero && (idx_q != '0)) ? {SEG_COUNT{1'b0}} : glyph};
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    busy_d     = busy_q;
    frame_d    = wrap;
    if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
    if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
    end
    // Taking the post-load pending value lets a load on the wrap tick land directly
    if (wrap) begin
      disp_val_d = pend_val_d;
      disp_dp_d  = pend_dp_d;
      busy_d     = 1'b0;
    end else if (load_i) begin
      busy_d = 1'b1;
    end
    if (!en_i || tick) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else begin
      seg_d = COMMON_ANODE ? ~raw : raw;
      an_d  = COMMON_ANODE ? ~an_sel : an_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      busy_q     <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      busy_q     <= busy_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign busy_o  = busy_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized and directed checks of seg7_scan_driver against a frame-position model
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int FR = ND * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blank = 1'b0;

  logic [7:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b;
  logic [0:0] an_c;
  logic       busy_a, busy_b, busy_c, frame_a, frame_b, frame_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .COMMON_ANODE(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .value_i(value), .dp_i(dp),
    .blank_lz_i(blank), .seg_o(seg_a), .an_o(an_a), .busy_o(busy_a), .frame_o(frame_a));

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .COMMON_ANODE(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .value_i(value), .dp_i(dp),
    .blank_lz_i(blank), .seg_o(seg_b), .an_o(an_b), .busy_o(busy_b), .frame_o(frame_b));

  seg7_scan_driver #(.NUM_DIGITS(1), .CLK_DIV(CD), .COMMON_ANODE(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .value_i(value[3:0]), .dp_i(dp[0:0]),
    .blank_lz_i(blank), .seg_o(seg_c), .an_o(an_c), .busy_o(busy_c), .frame_o(frame_c));

  // Reference: position within the frame counted in enabled cycles; outputs kept active-high
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp, m_an;
  logic        m_busy, m_frame;
  logic [7:0]  m_seg;

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input int d, input logic [15:0] v, input logic [3:0] dpv, input logic bl);
    logic [15:0] upper;
    logic [6:0]  g;
    upper = v >> (4 * d);
    g = glyph_of(upper[3:0]);
    if (bl && d > 0 && upper == 16'h0) g = 7'h00;
    return {dpv[d], g};
  endfunction

  always @(posedge clk) begin : model
    int  d;
    bit  tick, wrap;
    if (rst) begin
      m_pos <= 0; m_disp <= 0; m_disp_dp <= 0; m_pend <= 0; m_pend_dp <= 0;
      m_busy <= 0; m_frame <= 0; m_seg <= 8'h00; m_an <= 4'h0;
    end else begin
      d    = m_pos / CD;
      tick = en && (m_pos % CD == CD - 1);
      wrap = tick && (d == ND - 1);
      if (!en || tick) begin
        m_seg <= 8'h00; m_an <= 4'h0;
      end else begin
        m_seg <= ref_seg(d, m_disp, m_disp_dp, blank); m_an <= 4'(1 << d);
      end
      m_frame <= wrap;
      if (load) begin m_pend <= value; m_pend_dp <= dp; end
      if (wrap) begin
        m_disp <= load ? value : m_pend; m_disp_dp <= load ? dp : m_pend_dp; m_busy <= 0;
      end else if (load) begin
        m_busy <= 1;
      end
      if (en) m_pos <= (m_pos + 1) % FR;
    end
  end

  logic [27:0] got_vec, exp_vec;
  assign got_vec = {seg_a, an_a, busy_a, frame_a, seg_b, an_b, busy_b, frame_b};
  assign exp_vec = {~m_seg, ~m_an, m_busy, m_frame, m_seg, m_an, m_busy, m_frame};

  task automatic test_reset();
    en = 1; load = 1; value = 16'($urandom); dp = 4'($urandom);
    repeat (2) @(negedge clk);
    total++;
    if ({seg_a, an_a, busy_a, frame_a} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_ca got=%h want=%h", {seg_a, an_a, busy_a, frame_a}, {8'hFF, 4'hF, 2'b00});
    end
    total++;
    if ({seg_b, an_b, busy_b, frame_b} !== 14'h0) begin
      bad++; $display("FAIL reset_cc got=%h want=0", {seg_b, an_b, busy_b, frame_b});
    end
    rst = 0; load = 0;
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || got_vec !== exp_vec) begin
      bad++; $display("FAIL reset_release busy=%b got=%h want=%h", busy_a, got_vec, exp_vec);
    end
  endtask

  task automatic test_scan();
    bit after = 0, saw = 0;
    blank = 0; dp = 4'h0; value = 16'h1234; load = 1; en = 1;
    for (int c = 0; c < 3 * FR; c++) begin
      @(negedge clk);
      load = 0;
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL scan c=%0d got=%h want=%h", c, got_vec, exp_vec); end
      if (frame_a) after = 1;
      if (after && an_a == 4'b1110) begin
        saw = 1; total++;
        if (seg_a !== 8'h99) begin bad++; $display("FAIL scan_digit0 got=%b want=%b", seg_a, 8'h99); end
      end
    end
    total++;
    if (!saw) begin bad++; $display("FAIL scan_digit0_seen got=0 want=1"); end
  endtask

  task automatic test_midframe_load();
    int n = 0;
    bit after = 0, saw = 0;
    while (m_pos != CD + 1 && n < 3 * FR) begin @(negedge clk); n++; end
    total++;
    if (n >= 3 * FR) begin bad++; $display("FAIL midload_sync got=timeout want=pos"); end
    value = 16'hABCD; dp = 4'h0; load = 1;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      load = 0;
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL midload c=%0d got=%h want=%h", c, got_vec, exp_vec); end
      if (frame_a) after = 1;
      if (!after) begin
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL midload_busy c=%0d got=%b want=1", c, busy_a); end
      end else if (an_a == 4'b1110) begin
        saw = 1; total++;
        if (seg_a !== 8'hA1) begin bad++; $display("FAIL midload_digit0 got=%b want=%b", seg_a, 8'hA1); end
      end
    end
    total++;
    if (!saw) begin bad++; $display("FAIL midload_frame_seen got=0 want=1"); end
  endtask

  task automatic test_wrap_load();
    int n = 0;
    while (m_pos != FR - 1 && n < 3 * FR) begin @(negedge clk); n++; end
    total++;
    if (n >= 3 * FR) begin bad++; $display("FAIL wrapload_sync got=timeout want=pos"); end
    value = 16'($urandom); dp = 4'($urandom); load = 1;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      load = 0;
      total++;
      if (got_vec !== exp_vec || busy_a !== 1'b0) begin
        bad++; $display("FAIL wrapload c=%0d busy=%b got=%h want=%h", c, busy_a, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_blank();
    int n = 0;
    bit after = 0;
    logic [7:0] cap [4];
    for (int i = 0; i < 4; i++) cap[i] = 8'h00;
    while (m_pos != 2 && n < 3 * FR) begin @(negedge clk); n++; end
    blank = 1; value = 16'h0050; dp = 4'b0100; load = 1;
    for (int c = 0; c < 3 * FR; c++) begin
      @(negedge clk);
      load = 0;
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL blank c=%0d got=%h want=%h", c, got_vec, exp_vec); end
      if (frame_a) after = 1;
      if (after) for (int i = 0; i < 4; i++) if (an_a[i] == 1'b0) cap[i] = seg_a;
    end
    total++;
    if ({cap[3], cap[2], cap[1], cap[0]} !== {8'hFF, 8'h7F, 8'h92, 8'hC0}) begin
      bad++; $display("FAIL blank_digits got=%h want=%h", {cap[3], cap[2], cap[1], cap[0]}, {8'hFF, 8'h7F, 8'h92, 8'hC0});
    end
    blank = 0;
  endtask

  task automatic test_enable_pause();
    int n = 0;
    while (m_pos != 2 * CD + 2 && n < 3 * FR) begin @(negedge clk); n++; end
    total++;
    if (n >= 3 * FR) begin bad++; $display("FAIL pause_sync got=timeout want=pos"); end
    en = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load = (c == 4);
      value = 16'($urandom);
      total++;
      if (got_vec !== exp_vec || an_a !== 4'hF || frame_a !== 1'b0) begin
        bad++; $display("FAIL pause c=%0d an=%b frame=%b got=%h want=%h", c, an_a, frame_a, got_vec, exp_vec);
      end
    end
    en = 1; load = 0;
    for (int c = 0; c < 2 * CD; c++) begin
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL resume c=%0d got=%h want=%h", c, got_vec, exp_vec); end
      if (c == 0) begin
        total++;
        if (an_a !== 4'b1011) begin bad++; $display("FAIL resume_index got=%b want=1011", an_a); end
      end
    end
  endtask

  task automatic test_reset_busy();
    int n = 0;
    while (m_pos != CD && n < 3 * FR) begin @(negedge clk); n++; end
    value = 16'($urandom); dp = 4'($urandom); load = 1;
    @(negedge clk);
    load = 0;
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL rstbusy_pre got=%b want=1", busy_a); end
    rst = 1;
    @(negedge clk);
    total++;
    if ({seg_a, an_a, busy_a, frame_a, seg_b, an_b, busy_b, frame_b} !== {8'hFF, 4'hF, 2'b00, 14'h0}) begin
      bad++; $display("FAIL rstbusy_off got=%h want=%h", got_vec, {8'hFF, 4'hF, 2'b00, 14'h0});
    end
    rst = 0;
    for (int c = 0; c < FR + 2; c++) begin
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec || busy_a !== 1'b0) begin
        bad++; $display("FAIL rstbusy c=%0d busy=%b got=%h want=%h", c, busy_a, got_vec, exp_vec);
      end
      if (c == 0) begin
        total++;
        if (an_a !== 4'b1110) begin bad++; $display("FAIL rstbusy_digit0 got=%b want=1110", an_a); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL random c=%0d got=%h want=%h", c, got_vec, exp_vec); end
      rst   = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 7) != 0);
      load  = ($urandom_range(0, 9) == 0);
      value = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      dp    = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blank = ~blank;
    end
    rst = 0; en = 1; load = 0;
  endtask

  task automatic test_single_digit();
    int fa = 0, fc = 0;
    rst = 1; en = 1; load = 0;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < FR; c++) begin
      @(negedge clk);
      fa += int'(frame_a);
      fc += int'(frame_c);
    end
    total++;
    if (fc != 4 || fa != 1) begin bad++; $display("FAIL single_digit frames got=%0d/%0d want=4/1", fc, fa); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_wrap_load();
    test_blank();
    test_enable_pause();
    test_reset_busy();
    test_random();
    test_single_digit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
